elevator_control: RTL and testbench



---
 rtl/elevator_control.sv | 154 +++++++++++++++
 tb/tb_elevator_control.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/elevator_control.sv
// Single-car, four-floor elevator controller with SCAN scheduling.
// Hall calls latch into a pending mask; the car stops at each pending floor.
module elevator_control #(
    parameter int MOVE_CYCLES = 2,
    parameter int DOOR_CYCLES = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] up_req,
    input  logic [3:0] down_req,
    output logic [1:0] current_floor,
    output logic       moving_up,
    output logic       moving_down,
    output logic       door_open
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DOWN = 2'd2,
        DOOR      = 2'd3
    } state_t;

    localparam logic [7:0] MOVE_LAST = 8'(MOVE_CYCLES - 1);
    localparam logic [7:0] DOOR_LAST = 8'(DOOR_CYCLES - 1);

    state_t      state_reg, state_next;
    logic        dir_up_reg, dir_up_next;
    logic [7:0]  timer_reg, timer_next;
    logic [1:0]  floor_next;
    logic [3:0]  requests;
    logic [3:0]  clear_mask;
    logic        clear_en;

    function automatic logic req_above(input logic [3:0] r, input logic [1:0] f);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > int'(f)) hit = hit | r[i];
        end
        return hit;
    endfunction

    function automatic logic req_below(input logic [3:0] r, input logic [1:0] f);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i < int'(f)) hit = hit | r[i];
        end
        return hit;
    endfunction

    // Next-state: every transition restarts the shared travel/door timer.
    always_comb begin
        state_next  = state_reg;
        dir_up_next = dir_up_reg;
        floor_next  = current_floor;
        timer_next  = timer_reg;
        case (state_reg)
            IDLE: begin
                timer_next = 8'd0;
                if (requests[current_floor]) begin
                    state_next = DOOR;
                end else if (req_above(requests, current_floor)) begin
                    state_next  = MOVE_UP;
                    dir_up_next = 1'b1;
                end else if (req_below(requests, current_floor)) begin
                    state_next  = MOVE_DOWN;
                    dir_up_next = 1'b0;
                end
            end
            MOVE_UP, MOVE_DOWN: begin
                if (timer_reg == MOVE_LAST) begin
                    timer_next = 8'd0;
                    if (state_reg == MOVE_UP) begin
                        floor_next = (current_floor == 2'd3) ? current_floor : current_floor + 2'd1;
                    end else begin
                        floor_next = (current_floor == 2'd0) ? current_floor : current_floor - 2'd1;
                    end
                    if (requests[floor_next]) begin
                        state_next = DOOR;
                    end else if (state_reg == MOVE_UP && req_above(requests, floor_next)) begin
                        state_next = MOVE_UP;
                    end else if (state_reg == MOVE_DOWN && req_below(requests, floor_next)) begin
                        state_next = MOVE_DOWN;
                    end else if (state_reg == MOVE_UP && req_below(requests, floor_next)) begin
                        state_next  = MOVE_DOWN;
                        dir_up_next = 1'b0;
                    end else if (state_reg == MOVE_DOWN && req_above(requests, floor_next)) begin
                        state_next  = MOVE_UP;
                        dir_up_next = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    timer_next = timer_reg + 8'd1;
                end
            end
            DOOR: begin
                if (timer_reg == DOOR_LAST) begin
                    timer_next = 8'd0;
                    if (dir_up_reg && req_above(requests, current_floor)) begin
                        state_next = MOVE_UP;
                    end else if (!dir_up_reg && req_below(requests, current_floor)) begin
                        state_next = MOVE_DOWN;
                    end else if (dir_up_reg && req_below(requests, current_floor)) begin
                        state_next  = MOVE_DOWN;
                        dir_up_next = 1'b0;
                    end else if (!dir_up_reg && req_above(requests, current_floor)) begin
                        state_next  = MOVE_UP;
                        dir_up_next = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    timer_next = timer_reg + 8'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Calls for the floor being served are swallowed for the whole stop.
    assign clear_en = (state_next == DOOR) || (state_reg == DOOR);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_clear
            assign clear_mask[gi] = clear_en && (floor_next == 2'(gi));
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            dir_up_reg    <= 1'b1;
            timer_reg     <= 8'd0;
            current_floor <= 2'd0;
            requests      <= 4'd0;
            moving_up     <= 1'b0;
            moving_down   <= 1'b0;
            door_open     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            dir_up_reg    <= dir_up_next;
            timer_reg     <= timer_next;
            current_floor <= floor_next;
            requests      <= (requests | up_req | down_req) & ~clear_mask;
            moving_up     <= (state_next == MOVE_UP);
            moving_down   <= (state_next == MOVE_DOWN);
            door_open     <= (state_next == DOOR);
        end
    end

endmodule

// File: tb/tb_elevator_control.sv
// Directed plus random stimulus for elevator_control, checked each cycle
// against a floor/phase/countdown model of the SCAN policy.
module tb_elevator_control;

    localparam int MOVE_CYCLES = 2;
    localparam int DOOR_CYCLES = 3;

    logic       clk;
    logic       reset;
    logic [3:0] up_req;
    logic [3:0] down_req;
    logic [1:0] current_floor;
    logic       moving_up;
    logic       moving_down;
    logic       door_open;

    int compared;
    int mismatched;

    // Model: phase 0 = idle, 1 = travelling up, 2 = travelling down, 3 = door open
    int       m_floor;
    int       m_phase;
    int       m_left;
    bit       m_dir_up;
    bit [3:0] m_pend;

    elevator_control #(
        .MOVE_CYCLES(MOVE_CYCLES),
        .DOOR_CYCLES(DOOR_CYCLES)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .up_req       (up_req),
        .down_req     (down_req),
        .current_floor(current_floor),
        .moving_up    (moving_up),
        .moving_down  (moving_down),
        .door_open    (door_open)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit any_above(bit [3:0] p, int f);
        for (int i = f + 1; i < 4; i++) if (p[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit any_below(bit [3:0] p, int f);
        for (int i = 0; i < f; i++) if (p[i]) return 1'b1;
        return 1'b0;
    endfunction

    // Preferred direction first, otherwise the other way, otherwise rest.
    function automatic int pick(bit [3:0] p, int f, bit pref_up);
        if (pref_up) return any_above(p, f) ? 1 : (any_below(p, f) ? 2 : 0);
        return any_below(p, f) ? 2 : (any_above(p, f) ? 1 : 0);
    endfunction

    task automatic model_reset();
        m_floor  = 0;
        m_phase  = 0;
        m_left   = 0;
        m_dir_up = 1'b1;
        m_pend   = 4'b0000;
    endtask

    task automatic model_step(bit [3:0] u, bit [3:0] d);
        bit [3:0] p;
        int old_phase;
        int nxt;
        p = m_pend;
        old_phase = m_phase;
        nxt = m_phase;
        case (m_phase)
            0: nxt = p[m_floor] ? 3 : pick(p, m_floor, 1'b1);
            1, 2: begin
                m_left--;
                if (m_left == 0) begin
                    m_floor = m_floor + ((m_phase == 1) ? 1 : -1);
                    nxt = p[m_floor] ? 3 : pick(p, m_floor, m_phase == 1);
                    m_left = -1;
                end
            end
            default: begin
                m_left--;
                if (m_left == 0) begin
                    nxt = pick(p, m_floor, m_dir_up);
                    m_left = -1;
                end
            end
        endcase
        if (nxt != old_phase || m_left == -1) begin
            if (nxt == 1) m_dir_up = 1'b1;
            if (nxt == 2) m_dir_up = 1'b0;
            m_left = (nxt == 3) ? DOOR_CYCLES : MOVE_CYCLES;
        end
        m_phase = nxt;
        m_pend = p | u | d;
        if (m_phase == 3 || old_phase == 3) m_pend[m_floor] = 1'b0;
    endtask

    task automatic check(string tag, logic [7:0] obs, logic [7:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        check({tag, ".floor"}, 8'(current_floor), 8'(m_floor));
        check({tag, ".up"},    8'(moving_up),     8'(m_phase == 1));
        check({tag, ".down"},  8'(moving_down),   8'(m_phase == 2));
        check({tag, ".door"},  8'(door_open),     8'(m_phase == 3));
        check({tag, ".req"},   8'(dut.requests),  8'(m_pend));
    endtask

    task automatic step(bit [3:0] u, bit [3:0] d, string tag);
        up_req   = u;
        down_req = d;
        @(posedge clk);
        model_step(u, d);
        #1;
        check_all(tag);
        $display("step %-8s up=%b down=%b floor=%0d mu=%0b md=%0b door=%0b req=%b",
                 tag, u, d, current_floor, moving_up, moving_down, door_open, dut.requests);
    endtask

    task automatic idle_steps(int n, string tag);
        for (int k = 0; k < n; k++) step(4'b0, 4'b0, tag);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        up_req     = 4'b0;
        down_req   = 4'b0;
        reset      = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        reset = 1'b0;

        // Two stops on the way up, passing floor 1.
        step(4'b0101, 4'b0000, "s1");
        step(4'b0101, 4'b0000, "s1");
        idle_steps(16, "s1");

        // Down call above the car still means travelling up.
        step(4'b0000, 4'b1000, "s2");
        idle_steps(10, "s2");

        // Go to floor 1, then up to 3 while a floor-0 call arrives.
        step(4'b0000, 4'b0010, "s3");
        idle_steps(12, "s3");
        step(4'b0000, 4'b1000, "s3");
        idle_steps(2, "s3");
        step(4'b0001, 4'b0000, "s3");
        idle_steps(26, "s3");

        // Same-floor call while the door is open is absorbed.
        step(4'b0100, 4'b0000, "s4");
        idle_steps(6, "s4");
        step(4'b0000, 4'b0100, "s4");
        idle_steps(10, "s4");

        // Door at floor 1 heading down, then calls at both ends.
        step(4'b0000, 4'b0010, "s5");
        idle_steps(4, "s5");
        step(4'b1001, 4'b0000, "s5");
        for (int k = 0; k < 60 && !(m_phase == 1 && m_floor >= 1); k++) step(4'b0, 4'b0, "s5");
        check("s5.moving_up_seen", 8'(moving_up), 8'd1);

        // Asynchronous reset between edges.
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        check_all("areset");
        @(negedge clk);
        reset = 1'b0;

        for (int k = 0; k < 1500; k++) begin
            bit [3:0] u;
            bit [3:0] d;
            u = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0;
            d = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0;
            step(u, d, "rand");
        end
        idle_steps(40, "drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
